// File: rtl/joy_dir_arbiter.sv
// -----------------------------------------------------------------------------
// joy_dir_arbiter
//
// Filters raw joystick directions for PLAYERS joysticks. Every player uses the
// same runtime-selected mode:
//   mode 0 : 8-way passthrough
//   mode 1 : 4-way, last pressed direction wins
//   mode 2 : 4-way, first pressed direction wins
//   mode 3 : 2-way horizontal (up/down masked), last pressed wins
// Outputs are registered one-hot directions (raw bits in mode 0) plus a
// one-cycle change pulse per player.
//
// Optional feature macro: JOYDIR_HOLD_EN
//   When defined, a direction is held for hold_len ce ticks after full release.
//   When undefined, full release returns straight to idle; ce and hold_len are
//   unused.
//
// Ports
//   clk       system clock (clk_sys domain)
//   reset     synchronous, active-high reset
//   ce        tick enable for hold counters only
//   mode      arbitration mode (see above)
//   hold_len  hold duration in ce ticks (JOYDIR_HOLD_EN only)
//   indir     raw directions, player p at [4p+3:4p] = {up,down,left,right}
//   outdir    filtered directions, same packing
//   changed   per-player pulse when that player's outdir changes
// -----------------------------------------------------------------------------
module joy_dir_arbiter #(
  parameter int PLAYERS = 2,
  parameter int HOLD_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic [1:0]             mode,
  input  logic [HOLD_W-1:0]      hold_len,
  input  logic [4*PLAYERS-1:0]   indir,
  output logic [4*PLAYERS-1:0]   outdir,
  output logic [PLAYERS-1:0]     changed
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOCK = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Highest bit index wins: up > down > left > right.
  function automatic logic [1:0] highest(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

  logic [1:0] mode_q;
  logic       mode_chg;
  logic [3:0] eff_mask;

  // A mode switch restarts every player from idle in the same cycle.
  assign mode_chg = (mode != mode_q);
  assign eff_mask = (mode == 2'd3) ? 4'b0011 : 4'b1111;

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    if (reset) mode_q <= 2'd0;
    else       mode_q <= mode;
  end

`ifndef JOYDIR_HOLD_EN
  // Without the hold feature these inputs have no function.
  logic unused_hold;
  assign unused_hold = ^{ce, hold_len};
`endif

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [3:0] in1, in2;
    logic [3:0] eff, rise;
    logic [3:0] out_q, out_nxt;
    logic       chg_q;
    state_t     state, state_start, state_nxt;
    logic [1:0] dir, dir_nxt;
`ifdef JOYDIR_HOLD_EN
    logic [HOLD_W-1:0] cnt, cnt_start, cnt_nxt;
`endif

    // Shared release path: hold if enabled and non-zero length, else idle.
    always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      eff         = in1 & eff_mask;
      rise        = eff & ~(in2 & eff_mask);
      state_start = mode_chg ? ST_IDLE : state;
      state_nxt   = state_start;
      dir_nxt     = dir;
`ifdef JOYDIR_HOLD_EN
      cnt_start   = mode_chg ? '0 : cnt;
      cnt_nxt     = cnt_start;
`endif

      if (mode == 2'd0) begin
        state_nxt = ST_IDLE;
      end else if (mode != 2'd2 && rise != 4'b0000) begin
        // Last-wins: any new press takes over, whatever the state.
        state_nxt = ST_LOCK;
        dir_nxt   = highest(rise);
      end else begin
        case (state_start)
          ST_LOCK: begin
            if (eff[dir]) begin
              state_nxt = ST_LOCK;
            end else if (eff != 4'b0000) begin
              // Locked direction released while others are held: fall back.
              state_nxt = ST_LOCK;
              dir_nxt   = highest(eff);
            end else begin
`ifdef JOYDIR_HOLD_EN
              if (hold_len != '0) begin
                state_nxt = ST_HOLD;
                cnt_nxt   = hold_len;
              end else begin
                state_nxt = ST_IDLE;
              end
`else
              state_nxt = ST_IDLE;
`endif
            end
          end
`ifdef JOYDIR_HOLD_EN
          ST_HOLD: begin
            if (eff != 4'b0000) begin
              state_nxt = ST_LOCK;
              dir_nxt   = highest(eff);
            end else if (ce) begin
              // The tick that would bring the count to zero ends the hold.
              if (cnt_start <= HOLD_W'(1)) begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
              end else begin
                cnt_nxt = cnt_start - HOLD_W'(1);
              end
            end
          end
`endif
          default: begin
            if (eff != 4'b0000) begin
              state_nxt = ST_LOCK;
              dir_nxt   = highest(eff);
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        endcase
      end

      if (mode == 2'd0)            out_nxt = in1;
      else if (state_nxt != ST_IDLE) out_nxt = onehot(dir_nxt);
      else                         out_nxt = 4'b0000;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        in1   <= 4'b0000;
        in2   <= 4'b0000;
        state <= ST_IDLE;
        dir   <= 2'd0;
        out_q <= 4'b0000;
        chg_q <= 1'b0;
`ifdef JOYDIR_HOLD_EN
        cnt   <= '0;
`endif
      end else begin
        in1   <= indir[4*p +: 4];
        in2   <= in1;
        state <= state_nxt;
        dir   <= dir_nxt;
        out_q <= out_nxt;
        chg_q <= (out_nxt != out_q);
`ifdef JOYDIR_HOLD_EN
        cnt   <= cnt_nxt;
`endif
      end
    end

    assign outdir[4*p +: 4] = out_q;
    assign changed[p]       = chg_q;
  end

endmodule

// File: tb/tb_joy_dir_arbiter.sv
module tb_joy_dir_arbiter;

  localparam int PLAYERS = 2;
  localparam int HOLD_W  = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               ce;
  logic [1:0]         mode;
  logic [HOLD_W-1:0]  hold_len;
  logic [7:0]         indir;
  logic [7:0]         outdir;
  logic [1:0]         changed;

  int checks = 0;
  int errors = 0;

  joy_dir_arbiter #(.PLAYERS(PLAYERS), .HOLD_W(HOLD_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .mode     (mode),
    .hold_len (hold_len),
    .indir    (indir),
    .outdir   (outdir),
    .changed  (changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] mode;
    logic [7:0] indir;
    logic [7:0] exp_out;
    logic [1:0] exp_chg;
  } vec_t;

  localparam int NVEC = 39;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Row k: inputs applied before edge k, expected outputs after that edge.
    // indir/outdir = {player1, player0}. hold_len stays 0 for the table.
    vecs[0]  = '{1'b1, 2'd1, 8'h00, 8'h00, 2'b00};
    vecs[1]  = '{1'b0, 2'd1, 8'h08, 8'h00, 2'b00};
    vecs[2]  = '{1'b0, 2'd1, 8'h08, 8'h08, 2'b01};
    vecs[3]  = '{1'b0, 2'd1, 8'h08, 8'h08, 2'b00};
    vecs[4]  = '{1'b0, 2'd1, 8'h00, 8'h08, 2'b00};
    vecs[5]  = '{1'b0, 2'd1, 8'h00, 8'h00, 2'b01};
    vecs[6]  = '{1'b0, 2'd1, 8'h01, 8'h00, 2'b00};
    vecs[7]  = '{1'b0, 2'd1, 8'h09, 8'h01, 2'b01};
    vecs[8]  = '{1'b0, 2'd1, 8'h01, 8'h08, 2'b01};
    vecs[9]  = '{1'b0, 2'd1, 8'h01, 8'h01, 2'b01};
    vecs[10] = '{1'b0, 2'd1, 8'h00, 8'h01, 2'b00};
    vecs[11] = '{1'b0, 2'd1, 8'h00, 8'h00, 2'b01};
    vecs[12] = '{1'b0, 2'd2, 8'h02, 8'h00, 2'b00};
    vecs[13] = '{1'b0, 2'd2, 8'h06, 8'h02, 2'b01};
    vecs[14] = '{1'b0, 2'd2, 8'h04, 8'h02, 2'b00};
    vecs[15] = '{1'b0, 2'd2, 8'h04, 8'h04, 2'b01};
    vecs[16] = '{1'b0, 2'd2, 8'h00, 8'h04, 2'b00};
    vecs[17] = '{1'b0, 2'd2, 8'h00, 8'h00, 2'b01};
    vecs[18] = '{1'b0, 2'd3, 8'h0F, 8'h00, 2'b00};
    vecs[19] = '{1'b0, 2'd3, 8'h0F, 8'h02, 2'b01};
    vecs[20] = '{1'b0, 2'd3, 8'h0F, 8'h02, 2'b00};
    vecs[21] = '{1'b0, 2'd0, 8'h0F, 8'h0F, 2'b01};
    vecs[22] = '{1'b0, 2'd0, 8'h0F, 8'h0F, 2'b00};
    vecs[23] = '{1'b0, 2'd0, 8'h00, 8'h0F, 2'b00};
    vecs[24] = '{1'b0, 2'd0, 8'h00, 8'h00, 2'b01};
    vecs[25] = '{1'b0, 2'd3, 8'h0C, 8'h00, 2'b00};
    vecs[26] = '{1'b0, 2'd3, 8'h0C, 8'h00, 2'b00};
    vecs[27] = '{1'b0, 2'd3, 8'h00, 8'h00, 2'b00};
    vecs[28] = '{1'b0, 2'd1, 8'h84, 8'h00, 2'b00};
    vecs[29] = '{1'b0, 2'd1, 8'h84, 8'h84, 2'b11};
    vecs[30] = '{1'b0, 2'd1, 8'h84, 8'h84, 2'b00};
    vecs[31] = '{1'b1, 2'd1, 8'h84, 8'h00, 2'b00};
    vecs[32] = '{1'b0, 2'd1, 8'h84, 8'h00, 2'b00};
    vecs[33] = '{1'b0, 2'd1, 8'h84, 8'h84, 2'b11};
    vecs[34] = '{1'b0, 2'd1, 8'h00, 8'h84, 2'b00};
    vecs[35] = '{1'b0, 2'd1, 8'h00, 8'h00, 2'b11};
    vecs[36] = '{1'b0, 2'd1, 8'h07, 8'h00, 2'b00};
    vecs[37] = '{1'b0, 2'd1, 8'h00, 8'h04, 2'b01};
    vecs[38] = '{1'b0, 2'd1, 8'h00, 8'h00, 2'b01};

    reset    = 1'b1;
    ce       = 1'b0;
    mode     = 2'd1;
    hold_len = '0;
    indir    = 8'h00;

    for (int i = 0; i < NVEC; i++) begin
      reset = vecs[i].rst;
      mode  = vecs[i].mode;
      indir = vecs[i].indir;
      step();
      check($sformatf("vec%0d_outdir", i), outdir, vecs[i].exp_out);
      check($sformatf("vec%0d_changed", i), {6'd0, changed}, {6'd0, vecs[i].exp_chg});
    end

`ifdef JOYDIR_HOLD_EN
    begin
      int ticks;
      bit done;

      // Lock up, release, and count ce ticks until the hold expires.
      hold_len = 8'd3;
      mode     = 2'd1;
      ce       = 1'b0;
      indir    = 8'h08;
      step(); step();
      check("hold_lock", outdir, 8'h08);
      indir = 8'h00;
      step(); step();
      check("hold_enter", outdir, 8'h08);
      ticks = 0;
      done  = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
        ce = (k % 4 == 3);
        step();
        if (ce) ticks++;
        if (outdir == 8'h00) begin
          done = 1'b1;
          check("hold_ticks", 8'(ticks), 8'd3);
          check("hold_release_chg", {6'd0, changed}, 8'h01);
        end else begin
          check("hold_persist", outdir, 8'h08);
        end
      end
      ce = 1'b0;
      check("hold_done", {7'd0, done}, 8'h01);

      // New press during the hold appears with the normal 2-cycle latency.
      indir = 8'h08;
      step(); step();
      indir = 8'h00;
      step(); step();
      for (int k = 0; k < 4; k++) begin
        ce = (k % 4 == 3);
        step();
      end
      ce = 1'b0;
      check("hold_mid", outdir, 8'h08);
      indir = 8'h01;
      step();
      check("hold_press_lat1", outdir, 8'h08);
      step();
      check("hold_press_lat2", outdir, 8'h01);
      check("hold_press_chg", {6'd0, changed}, 8'h01);
      indir = 8'h00;
      hold_len = '0;
      step(); step();
      check("hold_zero_len", outdir, 8'h00);
    end
`else
    // hold_len and ce have no effect: release goes straight to idle.
    hold_len = 8'd3;
    mode     = 2'd1;
    indir    = 8'h08;
    step(); step();
    check("nohold_lock", outdir, 8'h08);
    indir = 8'h00;
    ce    = 1'b1;
    step();
    check("nohold_lat", outdir, 8'h08);
    step();
    check("nohold_release", outdir, 8'h00);
    check("nohold_chg", {6'd0, changed}, 8'h01);
    ce = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
